// File: rtl/anneal_sweep_controller_pkg.sv
// anneal_sweep_controller_pkg: shared state encoding and Q4.3 I_0 format constants
package anneal_sweep_controller_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int I0_W_Q = 8;
  localparam int I0_FRAC = 3;
endpackage

// File: rtl/anneal_sweep_controller_if.sv
// anneal_sweep_controller_if: run control, annealing config and sweep status bundle
interface anneal_sweep_controller_if import anneal_sweep_controller_pkg::*; #(
  parameter int NUM_GROUPS = 3,
  parameter int CNT_W = 16,
  parameter int I0_W = I0_W_Q
);
  localparam int IDX_W = NUM_GROUPS > 1 ? $clog2(NUM_GROUPS) : 1;
  logic start;
  logic abort;
  logic [CNT_W-1:0] num_sweeps;
  logic [3:0] dwell;
  logic [I0_W-1:0] i0_start;
  logic [I0_W-1:0] i0_step;
  logic [I0_W-1:0] i0_max;
  logic [CNT_W-1:0] sweeps_per_step;
  logic [NUM_GROUPS-1:0] group_en;
  logic [IDX_W-1:0] group_idx;
  logic [I0_W-1:0] i0;
  logic [CNT_W-1:0] sweep_count;
  logic sample_valid;
  logic busy;
  logic done;
  modport master (
    output start, abort, num_sweeps, dwell, i0_start, i0_step, i0_max, sweeps_per_step,
    input group_en, group_idx, i0, sweep_count, sample_valid, busy, done
  );
  modport slave (
    input start, abort, num_sweeps, dwell, i0_start, i0_step, i0_max, sweeps_per_step,
    output group_en, group_idx, i0, sweep_count, sample_valid, busy, done
  );
endinterface

// File: rtl/anneal_sweep_controller_group_dwell_counter.sv
// group_dwell_counter: steps through update groups, each held for dwell_len cycles
module group_dwell_counter #(
  parameter int NUM_GROUPS = 3,
  parameter int IDX_W = 2
)(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic [3:0] dwell_len,
  output logic [IDX_W-1:0] group_idx,
  output logic sweep_end
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_GROUPS - 1);
  logic [3:0] cnt;
  logic dwell_end;
  always_comb begin
    dwell_end = cnt == dwell_len - 4'd1;
    sweep_end = en && dwell_end && group_idx == LAST;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      group_idx <= '0;
    end else if (clr) begin
      cnt <= '0;
      group_idx <= '0;
    end else if (en) begin
      cnt <= dwell_end ? 4'd0 : cnt + 1'b1;
      if (dwell_end) group_idx <= group_idx == LAST ? '0 : group_idx + 1'b1;
    end
endmodule

// File: rtl/anneal_sweep_controller.sv
// anneal_sweep_controller: sequences p-bit group updates per sweep and ramps I_0
module anneal_sweep_controller import anneal_sweep_controller_pkg::*; #(
  parameter int NUM_GROUPS = 3,
  parameter int CNT_W = 16,
  parameter int I0_W = I0_W_Q
)(
  input logic clk,
  input logic reset,
  anneal_sweep_controller_if.slave bus
);
  localparam int IDX_W = NUM_GROUPS > 1 ? $clog2(NUM_GROUPS) : 1;
  state_t state_q, state_n;
  logic [CNT_W-1:0] n_sweeps_q, sps_q, step_q, sweep_inc;
  logic [3:0] dwell_q;
  logic [I0_W-1:0] i0_step_q, i0_max_q;
  logic [I0_W:0] i0_sum;
  logic accept, run_en, sweep_end, final_sweep, anneal;
  always_comb begin
    accept = state_q == IDLE && bus.start && !bus.abort;
    run_en = state_q == RUN && !bus.abort;
    sweep_inc = &bus.sweep_count ? bus.sweep_count : bus.sweep_count + 1'b1;
    final_sweep = n_sweeps_q != '0 && sweep_inc == n_sweeps_q;
    anneal = sps_q != '0 && step_q == sps_q - 1'b1;
    i0_sum = {1'b0, bus.i0} + {1'b0, i0_step_q};
    state_n = state_q == IDLE ? (accept ? RUN : IDLE) :
              state_q == RUN ? (bus.abort ? IDLE : sweep_end && final_sweep ? DONE : RUN) : IDLE;
    bus.group_en = state_q == RUN ? NUM_GROUPS'(1) << bus.group_idx : '0;
    bus.busy = state_q == RUN;
    bus.done = state_q == DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_n;
  // step_q counts completed sweeps modulo sweeps_per_step so no divider is needed
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      n_sweeps_q <= '0;
      sps_q <= '0;
      step_q <= '0;
      dwell_q <= '0;
      i0_step_q <= '0;
      i0_max_q <= '0;
      bus.i0 <= '0;
      bus.sweep_count <= '0;
      bus.sample_valid <= 1'b0;
    end else begin
      bus.sample_valid <= sweep_end;
      if (accept) begin
        n_sweeps_q <= bus.num_sweeps;
        sps_q <= bus.sweeps_per_step;
        dwell_q <= bus.dwell == 4'd0 ? 4'd1 : bus.dwell;
        i0_step_q <= bus.i0_step;
        i0_max_q <= bus.i0_max;
        bus.i0 <= bus.i0_start;
        bus.sweep_count <= '0;
        step_q <= '0;
      end else if (sweep_end) begin
        bus.sweep_count <= sweep_inc;
        step_q <= anneal ? '0 : step_q + 1'b1;
        if (anneal && bus.i0 < i0_max_q)
          bus.i0 <= i0_sum > {1'b0, i0_max_q} ? i0_max_q : i0_sum[I0_W-1:0];
      end
    end
  group_dwell_counter #(.NUM_GROUPS(NUM_GROUPS), .IDX_W(IDX_W)) u_cnt (
    .clk(clk),
    .reset(reset),
    .en(run_en),
    .clr(!run_en),
    .dwell_len(dwell_q),
    .group_idx(bus.group_idx),
    .sweep_end(sweep_end)
  );
endmodule

// File: tb/tb_anneal_sweep_controller.sv
// tb_anneal_sweep_controller: directed table, random runs and corner sequences vs a cycle-index model
module tb_anneal_sweep_controller;
  typedef struct {int dwell; int ns; int i0s; int step; int imax; int sps;} cfg_t;
  typedef struct {cfg_t c; int ab; int ck; logic [2:0] en; int idx; int i0; int sc; logic sv; logic bz; logic dn;} vec_t;
  logic clk = 0, reset = 1;
  int total = 0, bad = 0;
  vec_t tbl[12];
  always #5 clk = ~clk;
  anneal_sweep_controller_if #(.NUM_GROUPS(3), .CNT_W(16), .I0_W(8)) bus();
  anneal_sweep_controller_if #(.NUM_GROUPS(2), .CNT_W(3), .I0_W(8)) sbus();
  anneal_sweep_controller #(.NUM_GROUPS(3), .CNT_W(16), .I0_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  anneal_sweep_controller #(.NUM_GROUPS(2), .CNT_W(3), .I0_W(8)) sdut (.clk(clk), .reset(reset), .bus(sbus));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pack();
    return {bus.group_en, bus.group_idx, bus.i0, bus.sweep_count, bus.sample_valid, bus.busy, bus.done};
  endfunction

  function automatic logic [7:0] spack();
    return {sbus.group_en, sbus.group_idx, sbus.sweep_count, sbus.busy, sbus.done};
  endfunction

  function automatic int i0_after(int s, cfg_t c);
    int v = c.i0s;
    for (int j = 1; j <= s; j++)
      if (c.sps != 0 && j % c.sps == 0 && v < c.imax) v = v + c.step > c.imax ? c.imax : v + c.step;
    return v;
  endfunction

  // k = number of clock edges since (and including) the edge that accepted start
  function automatic logic [31:0] model(int k, cfg_t c, int ab);
    int d = c.dwell == 0 ? 1 : c.dwell;
    int p = 3 * d;
    int t = c.ns * p;
    int s = 0, gi = 0;
    logic [2:0] en = 0;
    logic sv = 0, bz = 0, dn = 0;
    if (ab != 0 && k > ab) s = (ab - 1) / p;
    else if (c.ns != 0 && k > t) begin
      s = c.ns;
      sv = k == t + 1;
      dn = k == t + 1;
    end else begin
      s = (k - 1) / p;
      gi = ((k - 1) % p) / d;
      en = 3'(1 << gi);
      bz = 1;
      sv = k > 1 && (k - 1) % p == 0;
    end
    return {en, 2'(gi), 8'(i0_after(s, c)), 16'(s), sv, bz, dn};
  endfunction

  task automatic scramble();
    bus.num_sweeps = 16'($urandom);
    bus.dwell = 4'($urandom);
    bus.i0_start = 8'($urandom);
    bus.i0_step = 8'($urandom);
    bus.i0_max = 8'($urandom);
    bus.sweeps_per_step = 16'($urandom);
  endtask

  task automatic run_case(input cfg_t c, input int ab, input int ck, input logic [31:0] ckexp, input string nm);
    int d, t, lim, last;
    d = c.dwell == 0 ? 1 : c.dwell;
    t = c.ns * 3 * d;
    lim = ab != 0 ? ab + 2 : t + 3;
    last = ab != 0 ? ab : t + 1;
    @(negedge clk);
    bus.dwell = 4'(c.dwell);
    bus.num_sweeps = 16'(c.ns);
    bus.i0_start = 8'(c.i0s);
    bus.i0_step = 8'(c.step);
    bus.i0_max = 8'(c.imax);
    bus.sweeps_per_step = 16'(c.sps);
    bus.start = 1;
    bus.abort = 0;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      chk(nm, pack(), model(k, c, ab));
      if (k == ck) chk({nm, "_point"}, pack(), ckexp);
      bus.start = k <= last ? 1'($urandom) : 1'b0;
      bus.abort = k == ab;
      scramble();
    end
    bus.start = 0;
    bus.abort = 0;
  endtask

  initial begin
    cfg_t c;
    int ab;
    bus.start = 0; bus.abort = 0; scramble();
    sbus.start = 0; sbus.abort = 0; sbus.num_sweeps = 0; sbus.dwell = 1;
    sbus.i0_start = 3; sbus.i0_step = 1; sbus.i0_max = 9; sbus.sweeps_per_step = 0;
    tbl[0] = '{'{3, 2, 5, 1, 20, 0}, 0, 10, 3'b001, 0, 5, 1, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{'{3, 2, 5, 1, 20, 0}, 0, 19, 3'b000, 0, 5, 2, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{'{3, 2, 5, 1, 20, 0}, 0, 9, 3'b100, 2, 5, 0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{'{1, 4, 8, 4, 14, 1}, 0, 4, 3'b001, 0, 12, 1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{'{1, 4, 8, 4, 14, 1}, 0, 13, 3'b000, 0, 14, 4, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{'{2, 3, 9, 1, 30, 1}, 6, 7, 3'b000, 0, 9, 0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{'{0, 1, 7, 1, 30, 1}, 0, 4, 3'b000, 0, 8, 1, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{'{0, 1, 7, 1, 30, 1}, 0, 3, 3'b100, 2, 7, 0, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{'{1, 3, 20, 3, 10, 1}, 0, 10, 3'b000, 0, 20, 3, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{'{1, 4, 0, 5, 255, 2}, 0, 13, 3'b000, 0, 10, 4, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{'{1, 2, 250, 10, 255, 1}, 0, 7, 3'b000, 0, 255, 2, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{'{1, 2, 250, 10, 255, 1}, 0, 4, 3'b001, 0, 255, 1, 1'b1, 1'b1, 1'b0};
    #12;
    chk("reset_main", pack(), 0);
    chk("reset_small", spack(), 0);
    @(negedge clk) reset = 0;
    foreach (tbl[i])
      run_case(tbl[i].c, tbl[i].ab, tbl[i].ck,
               {tbl[i].en, 2'(tbl[i].idx), 8'(tbl[i].i0), 16'(tbl[i].sc), tbl[i].sv, tbl[i].bz, tbl[i].dn},
               $sformatf("vec%0d", i));
    for (int r = 0; r < 25; r++) begin
      c = '{$urandom_range(0, 4), $urandom_range(1, 4), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3)};
      ab = $urandom_range(0, 2) == 0 ? $urandom_range(1, c.ns * 3 * (c.dwell == 0 ? 1 : c.dwell)) : 0;
      run_case(c, ab, 0, 0, $sformatf("rand%0d", r));
    end
    run_case('{1, 0, 4, 2, 60, 3}, 40, 0, 0, "endless");
    @(negedge clk);
    bus.start = 1; bus.abort = 1;
    @(negedge clk);
    chk("start_abort_idle", {bus.busy, bus.group_en}, 0);
    bus.start = 0; bus.abort = 0;
    bus.dwell = 2; bus.num_sweeps = 3; bus.i0_start = 40; bus.sweeps_per_step = 1; bus.i0_step = 1; bus.i0_max = 90;
    bus.start = 1;
    @(negedge clk) bus.start = 0;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 reset = 1;
    #1 chk("async_reset", pack(), 0);
    @(negedge clk) reset = 0;
    bus.i0_start = 33; bus.start = 1;
    @(negedge clk) bus.start = 0;
    chk("restart", pack(), {3'b001, 2'd0, 8'd33, 16'd0, 1'b0, 1'b1, 1'b0});
    bus.abort = 1;
    @(negedge clk) bus.abort = 0;
    chk("restart_abort", pack(), {3'b000, 2'd0, 8'd33, 16'd0, 1'b0, 1'b0, 1'b0});
    sbus.start = 1;
    @(negedge clk) sbus.start = 0;
    repeat (8) @(negedge clk);
    chk("sat_k9", spack(), {2'b01, 1'b0, 3'd4, 1'b1, 1'b0});
    repeat (16) @(negedge clk);
    chk("sat_k25", spack(), {2'b01, 1'b0, 3'd7, 1'b1, 1'b0});
    sbus.abort = 1;
    @(negedge clk) sbus.abort = 0;
    chk("sat_abort", spack(), {2'b00, 1'b0, 3'd7, 1'b0, 1'b0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
